box_motion: RTL and testbench
=============================

Name: box_motion

Overview:
- Per-frame motion engine for the bouncing-box screensaver; sits directly upstream of the image renderer.
- Consumes the video timer's 32-bit frame counter and, once per new frame, advances box position by its velocity, reflects off screen edges, and cycles box colour on any bounce.
- Presents registered, atomically updated box_x/box_y/color to the renderer.

Parameters:
- SCREEN_WIDTH, 640, visible width in pixels
- SCREEN_HEIGHT, 480, visible height in pixels
- BOX_WIDTH, 100, box width in pixels
- BOX_HEIGHT, 100, box height in pixels
- INIT_X, 50, reset x position
- INIT_Y, 50, reset y position
- INIT_VX, 2, reset x velocity, signed, magnitude 1..7
- INIT_VY, 1, reset y velocity, signed, magnitude 1..7

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous, active-high reset
- frame  input  32  frame counter from video timer; any change = new frame
- pause  input  1  high: frame changes are consumed but motion is frozen
- box_x  output  10  box left edge, 0..SCREEN_WIDTH-BOX_WIDTH
- box_y  output  9  box top edge, 0..SCREEN_HEIGHT-BOX_HEIGHT
- color  output  3  {b,g,r} enable bits, never 0
- bounce  output  1  one-cycle pulse: committed update included an edge hit
- update  output  1  one-cycle pulse: box_x/box_y/color just changed

Behaviour:
- Constants: MAX_X = SCREEN_WIDTH-BOX_WIDTH (540); MAX_Y = SCREEN_HEIGHT-BOX_HEIGHT (380).
- Reset (clk edge with rst=1): box_x=INIT_X, box_y=INIT_Y, vx=INIT_VX, vy=INIT_VY, color=3'b111, bounce=0, update=0, frame_prev=frame, state=IDLE, pending=0. A reset mid-sequence aborts all working values. Nothing commits.
- Velocities are internal 4-bit two's complement. Trajectory arithmetic is signed, at least 2 bits wider than the position.
- FSM states: IDLE, STEP_X, STEP_Y, COMMIT.
- IDLE: if frame != frame_prev or pending, then frame_prev<=frame, pending<=0, go STEP_X; else stay.
- STEP_X: t = box_x + vx.
  - If t < 0: nx = -t, nvx = -vx, hx = 1.
  - Else if t > MAX_X: nx = 2*MAX_X - t, nvx = -vx, hx = 1.
  - Else: nx = t, nvx = vx, hx = 0.
  - Go STEP_Y.
- STEP_Y: same rule on y with MAX_Y, giving ny, nvy, hy. Go COMMIT.
- COMMIT:
  - If pause=1: outputs and velocities are unchanged, and update/bounce stay 0.
  - Otherwise: box_x<=nx, box_y<=ny, vx<=nvx, vy<=nvy, update<=1, bounce<=hx|hy.
  - If hx|hy, color advances once: 7 wraps to 1, otherwise color+1. A corner hit (hx and hy together) still advances only once.
  - Go IDLE.
- update and bounce are high for exactly the cycle after the COMMIT edge, then return to 0.
- Latency: new frame value sampled in IDLE at edge E. Outputs change at edge E+3, and update is high during cycle E+3..E+4.
- Frame change seen in any non-IDLE state sets pending=1. At most one frame is queued; further changes before IDLE are merged. frame_prev still tracks the latest value when pending is consumed.
- Frame wrap 0xFFFFFFFF to 0 is an ordinary change.
- Outputs are only ever written in COMMIT and reset, so the renderer never sees a half-updated position.
- Invariant: 0 <= box_x <= MAX_X and 0 <= box_y <= MAX_Y at all times after reset. The reflection overshoot is at most 7.

Test Plan:
- Reset defaults, then a single frame change 0->1: within 4 cycles box_x=52, box_y=51, color=7, update pulses once, bounce=0.
- INIT_X=539, INIT_VX=2, INIT_Y=50, INIT_VY=1, one frame: box_x=539, vx becomes -2, box_y=51, bounce=1, color 7->1; next frame box_x=537.
- INIT_X=1, INIT_VX=-3, one frame: box_x=2, vx=+3, color 7->1. INIT_Y=0, INIT_VY=-1: box_y=1.
- Corner: INIT_X=539, INIT_VX=2, INIT_Y=379, INIT_VY=2, one frame: box_x=539, box_y=379, both velocities negated, color advances exactly once (7->1), single bounce pulse.
- Frame changes twice during STEP_X/STEP_Y: exactly two commits total, two update pulses. pause=1 during a frame: no position change, no update pulse, and the frame is still consumed (no later catch-up).
- Assert rst in STEP_Y after a pending frame: outputs return to INIT values, color=7, no update pulse, and the FSM idles until the next frame change.

Source files
------------

// File: rtl/box_motion.sv
// box_motion: per-frame motion engine for the bouncing-box screensaver.
// Watches the video timer's frame counter and, once per new frame, steps
// the box by its velocity, reflects it off the screen edges, and cycles
// its colour on any bounce. Position and colour are written only in
// COMMIT, so the renderer always sees a consistent box.
module box_motion #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BOX_WIDTH     = 100,
    parameter int BOX_HEIGHT    = 100,
    parameter int INIT_X        = 50,
    parameter int INIT_Y        = 50,
    parameter int INIT_VX       = 2,
    parameter int INIT_VY       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] frame,
    input  logic        pause,
    output logic [9:0]  box_x,
    output logic [8:0]  box_y,
    output logic [2:0]  color,
    output logic        bounce,
    output logic        update
);

    localparam int MAX_X = SCREEN_WIDTH - BOX_WIDTH;
    localparam int MAX_Y = SCREEN_HEIGHT - BOX_HEIGHT;

    // Trajectory arithmetic runs 2 bits wider than the x position so an
    // overshoot in either direction is visible as a sign or range excess.
    localparam logic signed [11:0] MAX_X_S = 12'(MAX_X);
    localparam logic signed [11:0] MAX_Y_S = 12'(MAX_Y);

    // The reflected result is always back in range, so the far-edge
    // reflection 2*MAX - t can be formed modulo the position width.
    localparam logic [9:0] TWO_MAX_X_MOD = 10'(2 * MAX_X);
    localparam logic [8:0] TWO_MAX_Y_MOD = 9'(2 * MAX_Y);

    localparam logic [9:0] INIT_X_V  = 10'(INIT_X);
    localparam logic [8:0] INIT_Y_V  = 9'(INIT_Y);
    localparam logic [3:0] INIT_VX_V = 4'(INIT_VX);
    localparam logic [3:0] INIT_VY_V = 4'(INIT_VY);

    typedef enum logic [1:0] {
        IDLE,
        STEP_X,
        STEP_Y,
        COMMIT
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [31:0] r_frame_prev;
    logic        r_pending;

    logic [9:0]  r_box_x;
    logic [8:0]  r_box_y;
    logic [3:0]  r_vx;
    logic [3:0]  r_vy;
    logic [2:0]  r_color;
    logic        r_bounce;
    logic        r_update;

    // Working values computed in STEP_X / STEP_Y, applied in COMMIT.
    logic [9:0]  r_nx;
    logic [8:0]  r_ny;
    logic [3:0]  r_nvx;
    logic [3:0]  r_nvy;
    logic        r_hx;
    logic        r_hy;

    logic               w_frame_new;
    logic signed [11:0] w_tx;
    logic signed [11:0] w_ty;
    logic [9:0]         w_nx;
    logic [8:0]         w_ny;
    logic [3:0]         w_nvx;
    logic [3:0]         w_nvy;
    logic               w_hx;
    logic               w_hy;
    logic [2:0]         w_color_next;

    assign w_frame_new = (frame != r_frame_prev);

    assign w_tx = $signed({2'b00, r_box_x}) + $signed({{8{r_vx[3]}}, r_vx});
    assign w_ty = $signed({3'b000, r_box_y}) + $signed({{8{r_vy[3]}}, r_vy});

    assign w_color_next = (r_color == 3'd7) ? 3'd1 : r_color + 3'd1;

    // Reflect the tentative x and y positions off the screen edges.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_nx  = w_tx[9:0];
        w_nvx = r_vx;
        w_hx  = 1'b0;
        w_ny  = w_ty[8:0];
        w_nvy = r_vy;
        w_hy  = 1'b0;
        if (w_tx[11]) begin
            w_nx  = -w_tx[9:0];
            w_nvx = -r_vx;
            w_hx  = 1'b1;
        end else if (w_tx > MAX_X_S) begin
            w_nx  = TWO_MAX_X_MOD - w_tx[9:0];
            w_nvx = -r_vx;
            w_hx  = 1'b1;
        end
        if (w_ty[11]) begin
            w_ny  = -w_ty[8:0];
            w_nvy = -r_vy;
            w_hy  = 1'b1;
        end else if (w_ty > MAX_Y_S) begin
            w_ny  = TWO_MAX_Y_MOD - w_ty[8:0];
            w_nvy = -r_vy;
            w_hy  = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one pass IDLE -> STEP_X -> STEP_Y -> COMMIT per frame.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_frame_new || r_pending) w_next_state = STEP_X;
            STEP_X:  w_next_state = STEP_Y;
            STEP_Y:  w_next_state = COMMIT;
            COMMIT:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Frame tracking, working values and the committed outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_prev <= frame;
            r_pending    <= 1'b0;
            r_box_x      <= INIT_X_V;
            r_box_y      <= INIT_Y_V;
            r_vx         <= INIT_VX_V;
            r_vy         <= INIT_VY_V;
            r_color      <= 3'b111;
            r_bounce     <= 1'b0;
            r_update     <= 1'b0;
            r_nx         <= '0;
            r_ny         <= '0;
            r_nvx        <= '0;
            r_nvy        <= '0;
            r_hx         <= 1'b0;
            r_hy         <= 1'b0;
        end else begin
            r_update <= 1'b0;
            r_bounce <= 1'b0;

            // Track the latest frame value everywhere so back-to-back
            // changes during a step merge into a single queued frame.
            if (w_frame_new) begin
                r_frame_prev <= frame;
            end

            case (r_state)
                IDLE: begin
                    if (w_frame_new || r_pending) r_pending <= 1'b0;
                end
                STEP_X: begin
                    r_nx  <= w_nx;
                    r_nvx <= w_nvx;
                    r_hx  <= w_hx;
                end
                STEP_Y: begin
                    r_ny  <= w_ny;
                    r_nvy <= w_nvy;
                    r_hy  <= w_hy;
                end
                COMMIT: begin
                    if (!pause) begin
                        r_box_x  <= r_nx;
                        r_box_y  <= r_ny;
                        r_vx     <= r_nvx;
                        r_vy     <= r_nvy;
                        r_update <= 1'b1;
                        r_bounce <= r_hx | r_hy;
                        if (r_hx | r_hy) r_color <= w_color_next;
                    end
                end
                default: ;
            endcase

            if (w_frame_new && (r_state != IDLE)) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign box_x  = r_box_x;
    assign box_y  = r_box_y;
    assign color  = r_color;
    assign bounce = r_bounce;
    assign update = r_update;

endmodule

// File: tb/tb_box_motion.sv
// Testbench for box_motion: four instances with different start positions
// and velocities share one frame counter, and a behavioural model steps
// each box by the reflection rules once per expected commit.
module tb_box_motion;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        pause = 1'b0;
    logic [31:0] frame = 32'd0;

    logic [9:0] bx [4];
    logic [8:0] by [4];
    logic [2:0] bc [4];
    logic       bb [4];
    logic       bu [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Start conditions: default, right edge, left/top edge, bottom-right corner.
    int P_X  [4] = '{50, 539, 1, 539};
    int P_VX [4] = '{2, 2, -3, 2};
    int P_Y  [4] = '{50, 50, 0, 379};
    int P_VY [4] = '{1, 1, -1, 2};

    int m_x [4];
    int m_y [4];
    int m_vx[4];
    int m_vy[4];
    int m_c [4];
    bit m_hit[4];

    int upd_cnt[4] = '{default: 0};
    int bnc_cnt[4] = '{default: 0};
    int u_snap [4];
    int b_snap [4];

    always #5 clk = ~clk;

    box_motion u_dut0 (.clk(clk), .rst(rst), .frame(frame), .pause(pause),
        .box_x(bx[0]), .box_y(by[0]), .color(bc[0]), .bounce(bb[0]), .update(bu[0]));

    box_motion #(.INIT_X(539), .INIT_VX(2), .INIT_Y(50), .INIT_VY(1)) u_dut1 (
        .clk(clk), .rst(rst), .frame(frame), .pause(pause),
        .box_x(bx[1]), .box_y(by[1]), .color(bc[1]), .bounce(bb[1]), .update(bu[1]));

    box_motion #(.INIT_X(1), .INIT_VX(-3), .INIT_Y(0), .INIT_VY(-1)) u_dut2 (
        .clk(clk), .rst(rst), .frame(frame), .pause(pause),
        .box_x(bx[2]), .box_y(by[2]), .color(bc[2]), .bounce(bb[2]), .update(bu[2]));

    box_motion #(.INIT_X(539), .INIT_VX(2), .INIT_Y(379), .INIT_VY(2)) u_dut3 (
        .clk(clk), .rst(rst), .frame(frame), .pause(pause),
        .box_x(bx[3]), .box_y(by[3]), .color(bc[3]), .bounce(bb[3]), .update(bu[3]));

    // Count high cycles of update and bounce; a stretched pulse counts twice.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bu[i] === 1'b1) upd_cnt[i] <= upd_cnt[i] + 1;
            if (bb[i] === 1'b1) bnc_cnt[i] <= bnc_cnt[i] + 1;
        end
    end

    function automatic void reflect(input int p, input int v, input int mx,
                                    output int np, output int nv, output bit hit);
        int t;
        t = p + v;
        if (t < 0) begin
            np = -t; nv = -v; hit = 1'b1;
        end else if (t > mx) begin
            np = 2 * mx - t; nv = -v; hit = 1'b1;
        end else begin
            np = t; nv = v; hit = 1'b0;
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_x[i] = P_X[i]; m_y[i] = P_Y[i];
            m_vx[i] = P_VX[i]; m_vy[i] = P_VY[i];
            m_c[i] = 7; m_hit[i] = 1'b0;
        end
    endtask

    task automatic model_frame();
        int nx, nvx, ny, nvy;
        bit hx, hy;
        for (int i = 0; i < 4; i++) begin
            reflect(m_x[i], m_vx[i], 540, nx, nvx, hx);
            reflect(m_y[i], m_vy[i], 380, ny, nvy, hy);
            m_x[i] = nx; m_vx[i] = nvx;
            m_y[i] = ny; m_vy[i] = nvy;
            m_hit[i] = hx | hy;
            if (hx | hy) m_c[i] = (m_c[i] == 7) ? 1 : m_c[i] + 1;
        end
    endtask

    task automatic snap_counts();
        for (int i = 0; i < 4; i++) begin
            u_snap[i] = upd_cnt[i];
            b_snap[i] = bnc_cnt[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One frame change, held long enough for the whole step to finish.
    task automatic frame_step(input logic [31:0] f, input bit p);
        @(negedge clk);
        frame = f;
        pause = p;
        repeat (6) @(negedge clk);
        pause = 1'b0;
        if (!p) model_frame();
    endtask

    task automatic test_reset();
        do_reset();
        snap_counts();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bx[i] !== 10'(P_X[i]) || by[i] !== 9'(P_Y[i])) begin
                n_fail++;
                $display("FAIL reset_pos[%0d]: got (%0d,%0d) exp (%0d,%0d)", i, bx[i], by[i], P_X[i], P_Y[i]);
            end
            n_checks++;
            if (bc[i] !== 3'd7 || bu[i] !== 1'b0 || bb[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: got c=%0d u=%b b=%b exp c=7 u=0 b=0", i, bc[i], bu[i], bb[i]);
            end
            n_checks++;
            if (upd_cnt[i] != u_snap[i]) begin
                n_fail++;
                $display("FAIL reset_idle_upd[%0d]: got %0d pulses exp 0", i, upd_cnt[i] - u_snap[i]);
            end
        end
    endtask

    // First frame 0->1 with cycle-exact latency; all four edge cases step here.
    task automatic test_single_frame();
        snap_counts();
        @(negedge clk);
        frame = 32'd1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bx[0] !== 10'd50 || bu[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got x=%0d u=%b exp x=50 u=0", bx[0], bu[0]);
        end
        @(negedge clk);
        model_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bx[i] !== 10'(m_x[i]) || by[i] !== 9'(m_y[i]) || bc[i] !== 3'(m_c[i])) begin
                n_fail++;
                $display("FAIL single_out[%0d]: got (%0d,%0d,c%0d) exp (%0d,%0d,c%0d)", i, bx[i], by[i], bc[i], m_x[i], m_y[i], m_c[i]);
            end
            n_checks++;
            if (bu[i] !== 1'b1 || bb[i] !== m_hit[i]) begin
                n_fail++;
                $display("FAIL single_pulse[%0d]: got u=%b b=%b exp u=1 b=%b", i, bu[i], bb[i], m_hit[i]);
            end
        end
        n_checks++;
        if (bx[0] !== 10'd52 || by[0] !== 9'd51 || bc[0] !== 3'd7) begin
            n_fail++;
            $display("FAIL basic_step: got (%0d,%0d,c%0d) exp (52,51,c7)", bx[0], by[0], bc[0]);
        end
        n_checks++;
        if (bx[1] !== 10'd539 || by[1] !== 9'd51 || bc[1] !== 3'd1) begin
            n_fail++;
            $display("FAIL right_edge: got (%0d,%0d,c%0d) exp (539,51,c1)", bx[1], by[1], bc[1]);
        end
        n_checks++;
        if (bx[2] !== 10'd2 || by[2] !== 9'd1 || bc[2] !== 3'd1) begin
            n_fail++;
            $display("FAIL left_top_edge: got (%0d,%0d,c%0d) exp (2,1,c1)", bx[2], by[2], bc[2]);
        end
        n_checks++;
        if (bx[3] !== 10'd539 || by[3] !== 9'd379 || bc[3] !== 3'd1) begin
            n_fail++;
            $display("FAIL corner: got (%0d,%0d,c%0d) exp (539,379,c1)", bx[3], by[3], bc[3]);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bu[i] !== 1'b0 || bb[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL pulse_width[%0d]: got u=%b b=%b exp 0 0", i, bu[i], bb[i]);
            end
            n_checks++;
            if (upd_cnt[i] - u_snap[i] != 1 || bnc_cnt[i] - b_snap[i] != int'(m_hit[i])) begin
                n_fail++;
                $display("FAIL single_counts[%0d]: got upd=%0d bnc=%0d exp 1 %0d", i, upd_cnt[i] - u_snap[i], bnc_cnt[i] - b_snap[i], m_hit[i]);
            end
        end
    endtask

    // Second frame shows the negated velocities moving the box back.
    task automatic test_after_bounce();
        frame_step(frame + 32'd1, 1'b0);
        n_checks++;
        if (bx[1] !== 10'd537 || bx[2] !== 10'd5 || bx[3] !== 10'd537 || by[3] !== 9'd377) begin
            n_fail++;
            $display("FAIL after_bounce: got x1=%0d x2=%0d x3=%0d y3=%0d exp 537 5 537 377", bx[1], bx[2], bx[3], by[3]);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bx[i] !== 10'(m_x[i]) || by[i] !== 9'(m_y[i]) || bc[i] !== 3'(m_c[i])) begin
                n_fail++;
                $display("FAIL after_bounce_model[%0d]: got (%0d,%0d,c%0d) exp (%0d,%0d,c%0d)", i, bx[i], by[i], bc[i], m_x[i], m_y[i], m_c[i]);
            end
        end
    endtask

    // Two extra changes during STEP_X / STEP_Y merge into one queued frame.
    task automatic test_back_to_back();
        snap_counts();
        @(negedge clk);
        frame = frame + 32'd1;
        @(negedge clk);
        frame = frame + 32'd1;
        @(negedge clk);
        frame = frame + 32'd1;
        repeat (12) @(negedge clk);
        model_frame();
        model_frame();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bx[i] !== 10'(m_x[i]) || by[i] !== 9'(m_y[i]) || bc[i] !== 3'(m_c[i])) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: got (%0d,%0d,c%0d) exp (%0d,%0d,c%0d)", i, bx[i], by[i], bc[i], m_x[i], m_y[i], m_c[i]);
            end
            n_checks++;
            if (upd_cnt[i] - u_snap[i] != 2) begin
                n_fail++;
                $display("FAIL b2b_updates[%0d]: got %0d exp 2", i, upd_cnt[i] - u_snap[i]);
            end
        end
    endtask

    // Paused frame is consumed without motion and never replayed.
    task automatic test_pause();
        snap_counts();
        frame_step(frame + 32'd1, 1'b1);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bx[i] !== 10'(m_x[i]) || by[i] !== 9'(m_y[i]) || bc[i] !== 3'(m_c[i])) begin
                n_fail++;
                $display("FAIL pause_out[%0d]: got (%0d,%0d,c%0d) exp (%0d,%0d,c%0d)", i, bx[i], by[i], bc[i], m_x[i], m_y[i], m_c[i]);
            end
            n_checks++;
            if (upd_cnt[i] != u_snap[i] || bnc_cnt[i] != b_snap[i]) begin
                n_fail++;
                $display("FAIL pause_pulses[%0d]: got upd=%0d bnc=%0d exp 0 0", i, upd_cnt[i] - u_snap[i], bnc_cnt[i] - b_snap[i]);
            end
        end
    endtask

    // Counter wrap is an ordinary change.
    task automatic test_wrap();
        snap_counts();
        frame_step(32'hFFFF_FFFF, 1'b0);
        frame_step(32'h0000_0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bx[i] !== 10'(m_x[i]) || by[i] !== 9'(m_y[i]) || upd_cnt[i] - u_snap[i] != 2) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got (%0d,%0d) upd=%0d exp (%0d,%0d) upd=2", i, bx[i], by[i], upd_cnt[i] - u_snap[i], m_x[i], m_y[i]);
            end
        end
    endtask

    // Reset in STEP_Y with a frame queued: everything aborts, FSM idles.
    task automatic test_reset_mid();
        snap_counts();
        @(negedge clk);
        frame = frame + 32'd1;
        @(negedge clk);
        frame = frame + 32'd1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bx[i] !== 10'(P_X[i]) || by[i] !== 9'(P_Y[i]) || bc[i] !== 3'd7) begin
                n_fail++;
                $display("FAIL rst_mid_out[%0d]: got (%0d,%0d,c%0d) exp (%0d,%0d,c7)", i, bx[i], by[i], bc[i], P_X[i], P_Y[i]);
            end
            n_checks++;
            if (upd_cnt[i] != u_snap[i]) begin
                n_fail++;
                $display("FAIL rst_mid_upd[%0d]: got %0d exp 0", i, upd_cnt[i] - u_snap[i]);
            end
        end
        snap_counts();
        frame_step(frame + 32'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bx[i] !== 10'(m_x[i]) || by[i] !== 9'(m_y[i]) || upd_cnt[i] - u_snap[i] != 1) begin
                n_fail++;
                $display("FAIL rst_mid_resume[%0d]: got (%0d,%0d) upd=%0d exp (%0d,%0d) upd=1", i, bx[i], by[i], upd_cnt[i] - u_snap[i], m_x[i], m_y[i]);
            end
        end
    endtask

    // Long random run with random frame jumps and random pauses.
    task automatic test_random();
        logic [31:0] f;
        bit p;
        for (int n = 0; n < 400; n++) begin
            f = frame + 32'($urandom_range(1, 1000));
            p = ($urandom_range(0, 3) == 0);
            snap_counts();
            frame_step(f, p);
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (bx[i] !== 10'(m_x[i]) || by[i] !== 9'(m_y[i]) || bc[i] !== 3'(m_c[i])) begin
                    n_fail++;
                    $display("FAIL rand_out[%0d] iter %0d: got (%0d,%0d,c%0d) exp (%0d,%0d,c%0d)", i, n, bx[i], by[i], bc[i], m_x[i], m_y[i], m_c[i]);
                end
                n_checks++;
                if (upd_cnt[i] - u_snap[i] != (p ? 0 : 1) || bnc_cnt[i] - b_snap[i] != ((!p && m_hit[i]) ? 1 : 0)) begin
                    n_fail++;
                    $display("FAIL rand_pulses[%0d] iter %0d: got upd=%0d bnc=%0d pause=%b", i, n, upd_cnt[i] - u_snap[i], bnc_cnt[i] - b_snap[i], p);
                end
                n_checks++;
                if (bx[i] > 10'd540 || by[i] > 9'd380 || bc[i] == 3'd0) begin
                    n_fail++;
                    $display("FAIL rand_range[%0d] iter %0d: got (%0d,%0d,c%0d) exp x<=540 y<=380 c!=0", i, n, bx[i], by[i], bc[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_after_bounce();
        test_back_to_back();
        test_pause();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
